// File: rtl/pwm1_regs.sv
// pwm1_regs -- register front end for the PWM1 generator.
//
// Single-beat bus reads and writes land in a shadow register set. A COMMIT
// (CTRL bit0) arms a transfer of the whole shadow set into the active
// outputs. The transfer happens only on a PWM period boundary, or at once
// while the generator is off. The generator therefore never runs a period
// with a mix of old and new settings.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-high reset
//   cmd_valid_i/ready_o   command handshake
//   cmd_we_i              1 = write, 0 = read
//   cmd_addr_i            byte address inside the register window
//   cmd_wdata_i/wstrb_i   write data and byte enables
//   rsp_valid_o/ready_i   response handshake
//   rsp_rdata_o           read data (0 for writes and errors)
//   rsp_err_o             access error
//   pwm1_*_o              active configuration driving the generator
//
// Register map (byte offsets)
//   0x00 MODE[1:0]  0x04 PERIOD  0x08 THRESH1  0x0C THRESH2  0x10 STEP[11:0]
//   0x14 CTRL  write: bit0 commit, bit1 clear cfg_err
//              read:  bit0 pending, bit1 cfg_err
module pwm1_regs #(
    parameter int          ADDR_W     = 5,
    parameter logic [31:0] PERIOD_RST = 32'd1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_wdata_i,
    input  logic [3:0]        cmd_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [1:0]        pwm1_mode_o,
    output logic [31:0]       pwm1_period_o,
    output logic [31:0]       pwm1_threshold1_o,
    output logic [31:0]       pwm1_threshold2_o,
    output logic [11:0]       pwm1_step_o
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [2:0] IDX_MODE   = 3'd0;
    localparam logic [2:0] IDX_PERIOD = 3'd1;
    localparam logic [2:0] IDX_THR1   = 3'd2;
    localparam logic [2:0] IDX_THR2   = 3'd3;
    localparam logic [2:0] IDX_STEP   = 3'd4;
    localparam logic [2:0] IDX_CTRL   = 3'd5;

    state_t      state;

    logic [1:0]  sh_mode;
    logic [31:0] sh_period;
    logic [31:0] sh_thr1;
    logic [31:0] sh_thr2;
    logic [11:0] sh_step;

    logic        pending;
    logic        cfg_err;
    logic [31:0] cnt;

    // Byte-lane merge of write data into the current register contents.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

    logic [31:0] addr_ext;
    logic [2:0]  reg_idx;
    logic        bad_addr;
    logic        accept;
    logic [31:0] rd_val;
    logic [31:0] new_word;
    logic        acc_err;
    logic        wr_ok;
    logic        commit_req;
    logic        reject;
    logic        clr_err;
    logic        boundary;
    logic        apply;

    assign addr_ext = 32'(cmd_addr_i);
    assign reg_idx  = addr_ext[4:2];
    assign bad_addr = (addr_ext[1:0] != 2'b00) || (addr_ext > 32'h14);
    assign accept   = cmd_valid_i && cmd_ready_o;

    // Boundary is the last count of the active period; active period is never 0.
    assign boundary = (cnt == pwm1_period_o - 32'd1);
    assign apply    = pending && ((pwm1_mode_o == 2'd0) || boundary);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        rd_val     = '0;
        acc_err    = 1'b0;
        wr_ok      = 1'b0;
        commit_req = 1'b0;
        reject     = 1'b0;
        clr_err    = 1'b0;

        if (!bad_addr) begin
            case (reg_idx)
                IDX_MODE:   rd_val = {30'd0, sh_mode};
                IDX_PERIOD: rd_val = sh_period;
                IDX_THR1:   rd_val = sh_thr1;
                IDX_THR2:   rd_val = sh_thr2;
                IDX_STEP:   rd_val = {20'd0, sh_step};
                IDX_CTRL:   rd_val = {30'd0, cfg_err, pending};
                default:    rd_val = '0;
            endcase
        end

        // Writes merge into the zero-extended shadow value, so bits beyond a
        // register's width simply fall away when the result is stored.
        new_word = merge_bytes(rd_val, cmd_wdata_i, cmd_wstrb_i);

        acc_err = bad_addr ||
                  (cmd_we_i && (reg_idx == IDX_PERIOD) && (new_word == 32'd0));

        wr_ok = accept && cmd_we_i && !acc_err;

        if (wr_ok && (reg_idx == IDX_CTRL) && cmd_wstrb_i[0]) begin
            commit_req = cmd_wdata_i[0];
            clr_err    = cmd_wdata_i[1];
        end

        // Validation looks at the staged values as they stand at the commit.
        reject = commit_req && (sh_mode == 2'd2) && (sh_thr2 < sh_thr1);
    end

    // Bus handshake FSM with registered response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= RESP;
                        cmd_ready_o <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= acc_err;
                        rsp_rdata_o <= (cmd_we_i || acc_err) ? 32'd0 : rd_val;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        cmd_ready_o <= 1'b1;
                        rsp_valid_o <= 1'b0;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_o <= 1'b1;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

    // Shadow registers, commit control, period counter and active set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_mode           <= '0;
            sh_period         <= PERIOD_RST;
            sh_thr1           <= '0;
            sh_thr2           <= '0;
            sh_step           <= '0;
            pending           <= 1'b0;
            cfg_err           <= 1'b0;
            cnt               <= '0;
            pwm1_mode_o       <= '0;
            pwm1_period_o     <= PERIOD_RST;
            pwm1_threshold1_o <= '0;
            pwm1_threshold2_o <= '0;
            pwm1_step_o       <= '0;
        end else begin
            if (wr_ok) begin
                case (reg_idx)
                    IDX_MODE:   sh_mode   <= new_word[1:0];
                    IDX_PERIOD: sh_period <= new_word;
                    IDX_THR1:   sh_thr1   <= new_word;
                    IDX_THR2:   sh_thr2   <= new_word;
                    IDX_STEP:   sh_step   <= new_word[11:0];
                    default:    ;
                endcase
            end

            // The apply edge transfers the shadow values as they were before
            // any write accepted on that same edge.
            if (apply) begin
                pwm1_mode_o       <= sh_mode;
                pwm1_period_o     <= sh_period;
                pwm1_threshold1_o <= sh_thr1;
                pwm1_threshold2_o <= sh_thr2;
                pwm1_step_o       <= sh_step;
                cnt               <= '0;
            end else if (pwm1_mode_o == 2'd0 || boundary) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end

            // A commit landing on the apply edge re-arms; the repeat transfer is harmless.
            if (apply)                   pending <= 1'b0;
            if (commit_req && !reject)   pending <= 1'b1;

            // A rejection wins over a clear carried in the same write.
            if (reject)       cfg_err <= 1'b1;
            else if (clr_err) cfg_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm1_regs.sv
// tb_pwm1_regs -- directed bench for pwm1_regs.
// Responses are checked against a queue of expected values filled as each
// command is driven. The active outputs are checked against values the bench
// works out from its own cycle count since the last transfer.
module tb_pwm1_regs;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [4:0]  cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_wstrb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [1:0]  pwm1_mode_o;
    logic [31:0] pwm1_period_o;
    logic [31:0] pwm1_threshold1_o;
    logic [31:0] pwm1_threshold2_o;
    logic [11:0] pwm1_step_o;

    pwm1_regs #(.ADDR_W(5), .PERIOD_RST(32'd1)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_we_i          (cmd_we_i),
        .cmd_addr_i        (cmd_addr_i),
        .cmd_wdata_i       (cmd_wdata_i),
        .cmd_wstrb_i       (cmd_wstrb_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready_i),
        .rsp_rdata_o       (rsp_rdata_o),
        .rsp_err_o         (rsp_err_o),
        .pwm1_mode_o       (pwm1_mode_o),
        .pwm1_period_o     (pwm1_period_o),
        .pwm1_threshold1_o (pwm1_threshold1_o),
        .pwm1_threshold2_o (pwm1_threshold2_o),
        .pwm1_step_o       (pwm1_step_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   apply_cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] mode, input logic [31:0] period,
                                 input logic [31:0] t1, input logic [31:0] t2, input logic [11:0] stp);
        check({tag, " mode"},    {30'd0, pwm1_mode_o},  {30'd0, mode});
        check({tag, " period"},  pwm1_period_o,         period);
        check({tag, " thresh1"}, pwm1_threshold1_o,     t1);
        check({tag, " thresh2"}, pwm1_threshold2_o,     t2);
        check({tag, " step"},    {20'd0, pwm1_step_o},  {20'd0, stp});
    endtask

    // Drive one command, wait for its response and compare it with the
    // scoreboard entry. Leaves the response pending (not yet handshaken).
    task automatic bus_start(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                             input logic exp_err, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!cmd_ready_o && n < 20) begin step(); n++; end
        check({tag, " cmd_ready"}, {31'd0, cmd_ready_o}, 32'd1);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_wstrb_i = wstrb;
        step();
        cmd_valid_i = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 20) begin step(); n++; end
        e = sb.pop_front();
        check({tag, " rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        check({tag, " rdata"},     rsp_rdata_o,          e.rdata);
        check({tag, " rsp_err"},   {31'd0, rsp_err_o},   {31'd0, e.err});
    endtask

    task automatic bus_end();
        step();
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic exp_err, input string tag);
        bus_start(1'b1, addr, wdata, wstrb, 32'd0, exp_err, tag);
        bus_end();
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input logic exp_err,
                      input string tag);
        bus_start(1'b0, addr, 32'd0, 4'h0, exp, exp_err, tag);
        bus_end();
    endtask

    function automatic int cnt_now();
        return (cyc - apply_cyc) % 10;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        cmd_wstrb_i = '0;
        rsp_ready_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;

        // Reset state
        check("rst cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        check("rst rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst rdata",     rsp_rdata_o,          32'd0);
        check("rst rsp_err",   {31'd0, rsp_err_o},   32'd0);
        check_outputs("rst", 2'd0, 32'd1, 32'd0, 32'd0, 12'd0);
        rd(5'h00, 32'd0, 1'b0, "rd MODE");
        rd(5'h04, 32'd1, 1'b0, "rd PERIOD");
        rd(5'h08, 32'd0, 1'b0, "rd THR1");
        rd(5'h0C, 32'd0, 1'b0, "rd THR2");
        rd(5'h10, 32'd0, 1'b0, "rd STEP");
        rd(5'h14, 32'd0, 1'b0, "rd CTRL");

        // Stage a configuration and commit while the generator is off
        wr(5'h04, 32'd10,        4'hF, 1'b0, "wr PERIOD");
        wr(5'h08, 32'd4,         4'hF, 1'b0, "wr THR1");
        wr(5'h0C, 32'd8,         4'hF, 1'b0, "wr THR2");
        wr(5'h10, 32'hDEAD1234,  4'h3, 1'b0, "wr STEP");
        wr(5'h00, 32'hFFFFFFFD,  4'hF, 1'b0, "wr MODE");
        rd(5'h10, 32'h234,       1'b0, "rd STEP masked");
        rd(5'h00, 32'd1,         1'b0, "rd MODE masked");
        bus_start(1'b1, 5'h14, 32'd1, 4'hF, 32'd0, 1'b0, "commit off");
        check_outputs("resp cycle", 2'd0, 32'd1, 32'd0, 32'd0, 12'd0);
        bus_end();
        apply_cyc = cyc;
        check_outputs("applied", 2'd1, 32'd10, 32'd4, 32'd8, 12'h234);
        rd(5'h14, 32'd0, 1'b0, "rd CTRL after apply");

        // Commit at counter 3 waits for the period boundary
        wr(5'h08, 32'd7, 4'hF, 1'b0, "wr THR1=7");
        n = 0;
        while (cnt_now() != 3 && n < 20) begin step(); n++; end
        wr(5'h14, 32'd1, 4'h1, 1'b0, "commit running");
        rd(5'h14, 32'd1, 1'b0, "rd CTRL pending");
        check("thr1 held mid-period", pwm1_threshold1_o, 32'd4);
        n = 0;
        while (cnt_now() != 9 && n < 20) begin step(); n++; end
        check("thr1 held at boundary", pwm1_threshold1_o, 32'd4);
        step();
        apply_cyc = cyc;
        check_outputs("boundary apply", 2'd1, 32'd10, 32'd7, 32'd8, 12'h234);
        rd(5'h14, 32'd0, 1'b0, "rd CTRL cleared");

        // Error accesses leave state alone
        wr(5'h04, 32'd0,       4'hF, 1'b1, "wr PERIOD=0");
        wr(5'h04, 32'h0,       4'h1, 1'b1, "wr PERIOD low byte 0");
        rd(5'h04, 32'd10,      1'b0, "rd PERIOD kept");
        wr(5'h18, 32'h1,       4'hF, 1'b1, "wr 0x18");
        wr(5'h02, 32'h1,       4'hF, 1'b1, "wr 0x02");
        rd(5'h1C, 32'd0,       1'b1, "rd 0x1C");
        rd(5'h09, 32'd0,       1'b1, "rd 0x09");

        // Rejected commit sets cfg_err and changes nothing
        wr(5'h00, 32'd2,   4'hF, 1'b0, "wr MODE=2");
        wr(5'h08, 32'd100, 4'hF, 1'b0, "wr THR1=100");
        wr(5'h0C, 32'd50,  4'hF, 1'b0, "wr THR2=50");
        wr(5'h14, 32'd1,   4'hF, 1'b0, "commit bad");
        rd(5'h14, 32'd2,   1'b0, "rd CTRL cfg_err");
        repeat (12) step();
        check_outputs("after reject", 2'd1, 32'd10, 32'd7, 32'd8, 12'h234);
        wr(5'h14, 32'd3,   4'hF, 1'b0, "clear+bad commit");
        rd(5'h14, 32'd2,   1'b0, "rd CTRL still err");
        wr(5'h14, 32'd2,   4'hF, 1'b0, "clear cfg_err");
        rd(5'h14, 32'd0,   1'b0, "rd CTRL clear");

        // Back-pressured response, then reset in the middle of it
        rsp_ready_i = 1'b0;
        bus_start(1'b0, 5'h10, 32'd0, 4'h0, 32'h234, 1'b0, "hold rd");
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
            check("hold rdata",     rsp_rdata_o,          32'h234);
            check("hold cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
        end
        rst_i = 1'b1;
        step();
        rst_i       = 1'b0;
        rsp_ready_i = 1'b1;
        check("mid rst rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("mid rst cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        check("mid rst rdata",     rsp_rdata_o,          32'd0);
        check_outputs("mid rst", 2'd0, 32'd1, 32'd0, 32'd0, 12'd0);
        rd(5'h00, 32'd0, 1'b0, "post rst MODE");
        rd(5'h04, 32'd1, 1'b0, "post rst PERIOD");
        rd(5'h08, 32'd0, 1'b0, "post rst THR1");
        rd(5'h0C, 32'd0, 1'b0, "post rst THR2");
        rd(5'h10, 32'd0, 1'b0, "post rst STEP");
        rd(5'h14, 32'd0, 1'b0, "post rst CTRL");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm1_regs.md
Name: pwm1_regs

Overview:
- Memory-mapped configuration stage placed directly upstream of the PWM1 generator.
- Accepts single-beat register reads and writes from the peripheral bus into staged (shadow) registers.
- Transfers the staged set atomically to the active outputs that drive the generator's mode/period/threshold1/threshold2/step inputs.
- Commits take effect only at a PWM period boundary, or immediately when the generator is off, so a period is never produced with a mixed configuration.

Parameters:
- ADDR_W, 5, byte-address width of the register window.
- PERIOD_RST, 32'd1, reset value of shadow and active PERIOD; must be non-zero.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  bus command valid
- cmd_ready_o  out  1  block can accept a command
- cmd_we_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_W  byte address
- cmd_wdata_i  in  32  write data
- cmd_wstrb_i  in  4  byte enables for writes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  32  read data; 0 for writes and errors
- rsp_err_o  out  1  access error
- pwm1_mode_o  out  2  active mode
- pwm1_period_o  out  32  active period
- pwm1_threshold1_o  out  32  active threshold1
- pwm1_threshold2_o  out  32  active threshold2
- pwm1_step_o  out  12  active step

Behaviour:
- Reset (rst_i=1 at an edge):
  - Outputs: cmd_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - Shadow and active values: mode=0, period=PERIOD_RST, thresholds=0, step=0.
  - pending=0, cfg_err=0, period counter=0, FSM to IDLE.
  - A reset asserted mid-transaction drops the outstanding response.
- Register map (byte offsets):
  - 0x00 MODE [1:0]
  - 0x04 PERIOD [31:0]
  - 0x08 THRESH1
  - 0x0C THRESH2
  - 0x10 STEP [11:0]
  - 0x14 CTRL: write bit0=1 issues COMMIT; read bit0=pending, bit1=cfg_err (write bit1=1 clears cfg_err).
  - Reads of 0x00–0x10 return shadow values, zero-extended.
- FSM has two states, IDLE and RESP:
  - IDLE: cmd_ready_o=1. A command is accepted when cmd_valid_i&cmd_ready_o; the shadow update happens at that edge and the FSM moves to RESP.
  - RESP: cmd_ready_o=0, rsp_valid_o=1, rsp_rdata_o and rsp_err_o held stable. Returns to IDLE on the edge where rsp_ready_i=1.
  - Minimum transaction length: 2 cycles. Next acceptance is possible in the cycle after the response handshake.
- Writes:
  - Applied per byte under cmd_wstrb_i. Bits outside a register's width are ignored.
  - Error (rsp_err_o=1, no state change) for: cmd_addr_i[1:0]!=0; address >0x14; a PERIOD write whose resulting value is 0.
  - Reads of illegal addresses return 0 with rsp_err_o=1.
- Commit:
  - A COMMIT write sets pending=1; a COMMIT while already pending is harmless.
  - Validation: if staged mode==2 and staged THRESH2<THRESH1, the commit is rejected. cfg_err is set, pending is not set, and the write response still has rsp_err_o=0.
  - Shadow writes while pending=1 are allowed; the values in place at the apply edge are what get transferred.
- Period counter:
  - Counts 0..active_period-1 while active mode!=0, then wraps to 0.
  - Held at 0 while active mode==0.
  - Boundary = counter==active_period-1.
- Apply:
  - Occurs at the edge where pending=1 and (active mode==0 or boundary).
  - All five active outputs load from shadow in the same edge; pending clears; counter goes to 0.
  - Outputs change only at apply edges or reset.
- Simultaneous events:
  - A COMMIT accepted on a boundary edge does not apply until the next boundary. pending becomes visible one edge later, so there is 1 cycle of minimum apply latency.
  - A cfg_err clear together with a rejected commit in the same write leaves cfg_err=1.

Test Plan:
- Reset, then read all registers → MODE=0, PERIOD=1, others 0, CTRL=0; outputs match, rsp_err_o=0.
- Write PERIOD=10, THRESH1=4, MODE=1, then COMMIT while active mode=0 → outputs update 1 cycle after the COMMIT response cycle; CTRL pending reads 0.
- Active mode=1 with period=10; write THRESH1=7 and COMMIT at counter=3 → pwm1_threshold1_o stays 4 until the edge after counter=9, then becomes 7; pending=1 is readable in between.
- Write PERIOD=0 with wstrb=4'hF → rsp_err_o=1, PERIOD read still 10. Write to 0x18 and to 0x02 → rsp_err_o=1.
- Staged MODE=2, THRESH1=100, THRESH2=50, then COMMIT → outputs unchanged, CTRL reads 2'b10; write CTRL=2 → reads 0.
- Hold rsp_ready_i=0 for 5 cycles → rsp_valid_o and rdata stable, cmd_ready_o=0. Assert rst_i in RESP → rsp_valid_o=0 next edge, all registers return to reset values.
